// File: rtl/alu_sequencer.sv
// Sequential front end for the datapath ALU: accepts one operation, decodes it into
// AluOp/busA/busB, captures the ALU result and returns it over a valid/ready response.
module alu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [15:0]      in_imm,
    output logic [3:0]       alu_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Packs {illegal, alu_op, busA, busB}; illegal ops park the ALU on opcode 4'hF with zero buses.
    function automatic logic [68:0] decode(input logic [4:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [15:0] imm);
        logic        ill;
        logic [31:0] opb;
        ill = 1'b0;
        opb = b;
        case (op)
            5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h0A, 5'h0B: opb = b;
            5'h10, 5'h11, 5'h12, 5'h16, 5'h1D: opb = {16'h0000, imm};
            5'h14, 5'h15:                      opb = {{16{imm[15]}}, imm};
            5'h1A, 5'h1B:                      opb = {27'h0000000, imm[4:0]};
            default:                           ill = 1'b1;
        endcase
        if (ill) begin
            decode = {1'b1, 4'hF, 32'h0000_0000, 32'h0000_0000};
        end else begin
            decode = {1'b0, op[3:0], a, opb};
        end
    endfunction

    logic [1:0]       state_q,     state_d;
    logic             in_ready_q,  in_ready_d;
    logic [3:0]       alu_op_q,    alu_op_d;
    logic [31:0]      alu_a_q,     alu_a_d;
    logic [31:0]      alu_b_q,     alu_b_d;
    logic             illegal_q,   illegal_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q,  out_data_d;
    logic             out_err_q,   out_err_d;
    logic [CNT_W-1:0] op_count_q,  op_count_d;
    logic [68:0]      dec_s;

    // Next-state and datapath capture for the IDLE -> EXEC -> HOLD handshake sequence.
    always_comb begin
        dec_s       = decode(in_op, in_a, in_b, in_imm);
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        op_count_d  = op_count_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    illegal_d  = dec_s[68];
                    alu_op_d   = dec_s[67:64];
                    alu_a_d    = dec_s[63:32];
                    alu_b_d    = dec_s[31:0];
                    in_ready_d = 1'b0;
                    state_d    = ST_EXEC;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_EXEC: begin
                out_data_d  = illegal_q ? 32'h0000_0000 : alu_res;
                out_err_d   = illegal_q;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            alu_op_q    <= 4'hF;
            alu_a_q     <= 32'h0000_0000;
            alu_b_q     <= 32'h0000_0000;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0000_0000;
            out_err_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            op_count_q  <= op_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign op_count  = op_count_q;

endmodule
